// File: rtl/mem_wb_pipe_if.sv
// Writeback packet bus between pipeline stages: NUM_CH parallel register-file
// write channels travelling together under one valid/ready pair.
interface mem_wb_pipe_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int OPC_W  = 7
);
  // Handshake: the master holds valid and payload stable until a cycle in which
  // ready is also high; that edge is the transfer. ready may depend on valid.
  logic                       valid;
  logic                       ready;
  logic [NUM_CH*DATA_W-1:0]   wdata;
  logic [NUM_CH-1:0]          we;
  logic [NUM_CH*ADDR_W-1:0]   waddr;
  logic [NUM_CH*OPC_W-1:0]    opcode;

  modport master (output valid, wdata, we, waddr, opcode, input ready);
  modport slave  (input valid, wdata, we, waddr, opcode, output ready);
endinterface

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline stage: DEPTH register stages carrying NUM_CH writeback channels.
// Optional MEM_WB_PIPE_PERF_EN adds perf_retired / perf_stall counters.
module mem_wb_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int OPC_W  = 7,
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 1,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  mem_wb_pipe_if.slave       in_bus,
  mem_wb_pipe_if.master      out_bus,
  output logic [OCC_W-1:0]   occupancy
`ifdef MEM_WB_PIPE_PERF_EN
  ,
  output logic [31:0]        perf_retired,
  output logic [31:0]        perf_stall
`endif
);

  logic [DEPTH-1:0]         valid_q;
  logic [NUM_CH*DATA_W-1:0] wdata_q  [DEPTH];
  logic [NUM_CH-1:0]        we_q     [DEPTH];
  logic [NUM_CH*ADDR_W-1:0] waddr_q  [DEPTH];
  logic [NUM_CH*OPC_W-1:0]  opcode_q [DEPTH];

  logic [DEPTH-1:0]         adv;
  logic [NUM_CH-1:0]        san_we;
  logic                     accept;

  // A stage may load while any downstream stage has a hole or the output drains.
  always_comb begin
    adv = '0;
    for (int k = 0; k < DEPTH; k++) begin
      adv[k] = out_bus.ready;
      for (int j = k + 1; j < DEPTH; j++) begin
        if (!valid_q[j]) adv[k] = 1'b1;
      end
    end
    adv[DEPTH-1] = out_bus.ready | ~valid_q[DEPTH-1];
  end

  assign in_bus.ready = adv[0] & ~flush;
  assign accept       = in_bus.valid & in_bus.ready;

  // x0 writes are dropped; on a duplicate destination the highest channel wins.
  always_comb begin
    san_we = in_bus.we;
    for (int i = 0; i < NUM_CH; i++) begin
      if (in_bus.waddr[i*ADDR_W +: ADDR_W] == '0) san_we[i] = 1'b0;
      for (int j = i + 1; j < NUM_CH; j++) begin
        if (in_bus.we[i] && in_bus.we[j] &&
            in_bus.waddr[i*ADDR_W +: ADDR_W] == in_bus.waddr[j*ADDR_W +: ADDR_W])
          san_we[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        wdata_q[k]  <= '0;
        we_q[k]     <= '0;
        waddr_q[k]  <= '0;
        opcode_q[k] <= '0;
      end
    end else begin
      if (adv[0]) valid_q[0] <= accept;
      if (accept) begin
        wdata_q[0]  <= in_bus.wdata;
        we_q[0]     <= san_we;
        waddr_q[0]  <= in_bus.waddr;
        opcode_q[0] <= in_bus.opcode;
      end
      // Payload only moves with a real packet, so vacated stages keep their contents.
      for (int k = 1; k < DEPTH; k++) begin
        if (adv[k]) valid_q[k] <= valid_q[k-1];
        if (adv[k] && valid_q[k-1] && !flush) begin
          wdata_q[k]  <= wdata_q[k-1];
          we_q[k]     <= we_q[k-1];
          waddr_q[k]  <= waddr_q[k-1];
          opcode_q[k] <= opcode_q[k-1];
        end
      end
      if (flush) valid_q <= '0;
    end
  end

  assign out_bus.valid  = valid_q[DEPTH-1];
  assign out_bus.we     = valid_q[DEPTH-1] ? we_q[DEPTH-1] : '0;
  assign out_bus.wdata  = wdata_q[DEPTH-1];
  assign out_bus.waddr  = waddr_q[DEPTH-1];
  assign out_bus.opcode = opcode_q[DEPTH-1];

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < DEPTH; k++) occupancy = occupancy + OCC_W'(valid_q[k]);
  end

`ifdef MEM_WB_PIPE_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_retired <= '0;
      perf_stall   <= '0;
    end else begin
      if (out_bus.valid && out_bus.ready)  perf_retired <= perf_retired + 32'd1;
      if (out_bus.valid && !out_bus.ready) perf_stall   <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Bench for mem_wb_pipe: a DEPTH=1 instance (a) and a DEPTH=3 instance (b),
// directed packets with hand-computed expectations checked by output monitors.
module tb_mem_wb_pipe;
  localparam int W = 2 + 10 + 64 + 14;

  logic clk = 1'b0;
  logic rst;
  logic flush_a, flush_b;
  logic [0:0] a_occ;
  logic [1:0] b_occ;
`ifdef MEM_WB_PIPE_PERF_EN
  logic [31:0] a_ret, a_stall, b_ret, b_stall;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] a_q[$];
  logic [W-1:0] b_q[$];

  mem_wb_pipe_if a_in ();
  mem_wb_pipe_if a_out ();
  mem_wb_pipe_if b_in ();
  mem_wb_pipe_if b_out ();

  mem_wb_pipe #(.DEPTH(1)) u_dut_a (
    .clk(clk), .rst(rst), .flush(flush_a), .in_bus(a_in), .out_bus(a_out), .occupancy(a_occ)
`ifdef MEM_WB_PIPE_PERF_EN
    , .perf_retired(a_ret), .perf_stall(a_stall)
`endif
  );

  mem_wb_pipe #(.DEPTH(3)) u_dut_b (
    .clk(clk), .rst(rst), .flush(flush_b), .in_bus(b_in), .out_bus(b_out), .occupancy(b_occ)
`ifdef MEM_WB_PIPE_PERF_EN
    , .perf_retired(b_ret), .perf_stall(b_stall)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  function automatic void check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  // Directed packet i for the deep-pipe tests: distinct, nonzero destinations.
  function automatic logic [63:0] pk_d(input int i);
    return {32'hB000_0000 + 32'(i), 32'hA000_0000 + 32'(i)};
  endfunction
  function automatic logic [9:0] pk_a(input int i);
    return {5'(i + 10), 5'(i + 1)};
  endfunction
  function automatic logic [13:0] pk_o(input int i);
    return {7'(i + 64), 7'(i)};
  endfunction

  // driver tasks
  task automatic put(input int sel, input logic [63:0] d, input logic [1:0] we,
                     input logic [9:0] addr, input logic [13:0] op);
    if (sel == 0) begin
      a_in.wdata = d; a_in.we = we; a_in.waddr = addr; a_in.opcode = op; a_in.valid = 1'b1;
    end else begin
      b_in.wdata = d; b_in.we = we; b_in.waddr = addr; b_in.opcode = op; b_in.valid = 1'b1;
    end
  endtask

  task automatic send(input int sel, input logic [63:0] d, input logic [1:0] we,
                      input logic [9:0] addr, input logic [13:0] op, input logic [1:0] exp_we);
    bit got = 0;
    int t = 0;
    put(sel, d, we, addr, op);
    while (!got && t < 20) begin
      @(negedge clk);
      if ((sel == 0) ? a_in.ready : b_in.ready) begin
        got = 1;
        if (sel == 0) a_q.push_back({exp_we, addr, d, op});
        else          b_q.push_back({exp_we, addr, d, op});
      end
      @(posedge clk); #1;
      t++;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL send_timeout: dut %0d never ready within %0d cycles", sel, t);
    end
    if (sel == 0) a_in.valid = 1'b0;
    else          b_in.valid = 1'b0;
  endtask

  task automatic send_p(input int sel, input int i);
    send(sel, pk_d(i), 2'b11, pk_a(i), pk_o(i), 2'b11);
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    if (!rst && a_out.valid && a_out.ready) begin
      checks++;
      if (a_q.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_out: got %0h expected no packet",
                 {a_out.we, a_out.waddr, a_out.wdata, a_out.opcode});
      end else begin
        checks--;
        check("a_out_pkt", {a_out.we, a_out.waddr, a_out.wdata, a_out.opcode}, a_q.pop_front());
      end
    end
    if (!rst && b_out.valid && b_out.ready) begin
      checks++;
      if (b_q.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_out: got %0h expected no packet",
                 {b_out.we, b_out.waddr, b_out.wdata, b_out.opcode});
      end else begin
        checks--;
        check("b_out_pkt", {b_out.we, b_out.waddr, b_out.wdata, b_out.opcode}, b_q.pop_front());
      end
    end
  end

  initial begin
    int acc;
    int idx;
    rst = 1'b1; flush_a = 1'b0; flush_b = 1'b0;
    a_in.valid = 1'b0; a_in.wdata = '0; a_in.we = '0; a_in.waddr = '0; a_in.opcode = '0;
    b_in.valid = 1'b0; b_in.wdata = '0; b_in.we = '0; b_in.waddr = '0; b_in.opcode = '0;
    a_out.ready = 1'b0; b_out.ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_a_valid", a_out.valid, 0);
    check("rst_a_we", a_out.we, 0);
    check("rst_a_wdata", a_out.wdata, 0);
    check("rst_a_waddr", a_out.waddr, 0);
    check("rst_a_opcode", a_out.opcode, 0);
    check("rst_a_occ", a_occ, 0);
    check("rst_a_in_ready", a_in.ready, 1);
    check("rst_b_valid", b_out.valid, 0);
    check("rst_b_occ", b_occ, 0);
    @(posedge clk); #1;

    // basic packet, DEPTH=1: visible one cycle after acceptance
    a_out.ready = 1'b1;
    send(0, {32'h22, 32'h11}, 2'b11, {5'd7, 5'd5}, {7'h23, 7'h03}, 2'b11);
    @(negedge clk);
    check("a_latency_valid", a_out.valid, 1);
    check("a_latency_we", a_out.we, 2'b11);
    @(posedge clk); #1;

    // sanitation: duplicate destination, x0 writes, disabled channels
    send(0, {32'h44, 32'h33}, 2'b11, {5'd3, 5'd3},  {7'h11, 7'h10}, 2'b10);
    send(0, {32'h66, 32'h55}, 2'b11, {5'd9, 5'd0},  {7'h13, 7'h12}, 2'b10);
    send(0, {32'h88, 32'h77}, 2'b01, {5'd4, 5'd4},  {7'h15, 7'h14}, 2'b01);
    send(0, {32'hAA, 32'h99}, 2'b11, {5'd0, 5'd0},  {7'h17, 7'h16}, 2'b00);
    send(0, {32'hCC, 32'hBB}, 2'b10, {5'd0, 5'd6},  {7'h19, 7'h18}, 2'b00);
    send(0, {32'hEE, 32'hDD}, 2'b11, {5'd31, 5'd1}, {7'h1B, 7'h1A}, 2'b11);
    repeat (2) @(posedge clk); #1;

    // DEPTH=3 backpressure: 5 offers, exactly 3 accepted, then in-order drain
    b_out.ready = 1'b0;
    acc = 0; idx = 0;
    for (int c = 0; c < 5; c++) begin
      put(1, pk_d(idx), 2'b11, pk_a(idx), pk_o(idx));
      @(negedge clk);
      if (b_in.ready) begin
        b_q.push_back({2'b11, pk_a(idx), pk_d(idx), pk_o(idx)});
        acc++; idx++;
      end
      @(posedge clk); #1;
    end
    b_in.valid = 1'b0;
    check("bp_accepted", acc, 3);
    @(negedge clk);
    check("bp_occ_full", b_occ, 3);
    check("bp_in_ready_low", b_in.ready, 0);
    check("bp_out_valid", b_out.valid, 1);
    @(posedge clk); #1;
    b_out.ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("drain_occ", b_occ, 0);
    check("drain_out_valid", b_out.valid, 0);
    check("drain_q_left", b_q.size(), 0);
    @(posedge clk); #1;

    // flush with a full pipe: head delivered, rest and offered input discarded
    b_out.ready = 1'b0;
    send_p(1, 4);
    send_p(1, 5);
    send_p(1, 6);
    @(negedge clk);
    check("flush_pre_occ", b_occ, 3);
    @(posedge clk); #1;
    flush_b = 1'b1;
    b_out.ready = 1'b1;
    put(1, pk_d(20), 2'b11, pk_a(20), pk_o(20));
    @(negedge clk);
    check("flush_in_ready", b_in.ready, 0);
    @(posedge clk); #1;
    flush_b = 1'b0;
    b_in.valid = 1'b0;
    check("flush_head_delivered", b_q.size(), 2);
    b_q.delete();
    @(negedge clk);
    check("flush_out_valid", b_out.valid, 0);
    check("flush_occ", b_occ, 0);
    check("flush_out_we", b_out.we, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("flush_no_capture", b_out.valid, 0);
    @(posedge clk); #1;

    // reset mid-stream with two packets inside
    b_out.ready = 1'b0;
    send_p(1, 7);
    send_p(1, 8);
    @(negedge clk);
    check("midrst_pre_occ", b_occ, 2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    b_q.delete();
    @(negedge clk);
    check("midrst_valid", b_out.valid, 0);
    check("midrst_we", b_out.we, 0);
    check("midrst_wdata", b_out.wdata, 0);
    check("midrst_waddr", b_out.waddr, 0);
    check("midrst_opcode", b_out.opcode, 0);
    check("midrst_occ", b_occ, 0);
    check("midrst_in_ready", b_in.ready, 1);
`ifdef MEM_WB_PIPE_PERF_EN
    check("midrst_b_retired", b_ret, 0);
    check("midrst_b_stall", b_stall, 0);
    check("midrst_a_retired", a_ret, 0);
    check("midrst_a_stall", a_stall, 0);
`endif
    @(posedge clk); #1;

    // DEPTH=1: one packet held for 3 stalled cycles, then 4 transfers total
    a_out.ready = 1'b0;
    send_p(0, 10);
    repeat (3) @(posedge clk);
    #1 a_out.ready = 1'b1;
    send_p(0, 11);
    send_p(0, 12);
    send_p(0, 13);
    @(posedge clk); #1;
    @(negedge clk);
    check("perf_seq_empty", a_occ, 0);
`ifdef MEM_WB_PIPE_PERF_EN
    check("perf_retired", a_ret, 4);
    check("perf_stall", a_stall, 3);
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("end_a_q_left", a_q.size(), 0);
    check("end_b_q_left", b_q.size(), 0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
